// File: rtl/serial_word_assembler_if.sv
// Bundles the serial-in / word-out signals of serial_word_assembler.
// The assembler is connected through the slave modport. The feeder or
// consumer is connected through the master modport.
// With PARITY_CHECK_EN defined, the interface also carries parity_err.
interface serial_word_assembler_if #(
    parameter int WIDTH = 3
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             bit_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    bit_count;
    logic             overrun;
`ifdef PARITY_CHECK_EN
    logic             parity_err;
`endif

    modport slave (
        input  bit_in, bit_valid, frame_start, word_ready,
        output word_out, word_valid, bit_count, overrun
`ifdef PARITY_CHECK_EN
        , output parity_err
`endif
    );

    modport master (
        output bit_in, bit_valid, frame_start, word_ready,
        input  word_out, word_valid, bit_count, overrun
`ifdef PARITY_CHECK_EN
        , input parity_err
`endif
    );
endinterface

// File: rtl/serial_word_assembler.sv
// Collects one serial bit per qualified cycle into a WIDTH-bit word.
// Each completed word is presented through a one-entry valid/ready buffer.
// When a completed word finds the buffer full and not draining, that word is
// dropped and the sticky overrun flag is set.
// Optional feature (macro PARITY_CHECK_EN): each frame carries one trailing
// even-parity bit. A frame with bad parity is discarded and parity_err pulses.
module serial_word_assembler #(
    parameter int WIDTH     = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_word_assembler_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_COLLECT, S_COMPLETE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_word;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic             r_overrun;
`ifdef PARITY_CHECK_EN
    logic             r_perr;
`endif

    // frame_start clears the partial word before this cycle's bit is shifted in.
    logic [WIDTH-1:0] w_base;
    logic [CW-1:0]    w_cnt_base;
    logic [WIDTH-1:0] w_shifted;

    assign w_base     = bus.frame_start ? '0 : r_shreg;
    assign w_cnt_base = bus.frame_start ? '0 : r_count;

    // Bit order: the first bit lands in the MSB or in the LSB.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shifted = {w_base[WIDTH-2:0], bus.bit_in};
        end else begin : g_lsb
            assign w_shifted = {bus.bit_in, w_base[WIDTH-1:1]};
        end
    endgenerate

`ifdef PARITY_CHECK_EN
    logic w_is_par;
    logic w_par_ok;
    assign w_is_par = (w_cnt_base == CW'(WIDTH));
    assign w_par_ok = ~(^w_base ^ bus.bit_in);
`else
    logic w_last;
    assign w_last = (w_cnt_base == CW'(WIDTH - 1));
`endif

    // Collector FSM and output buffer.
    // COMPLETE lasts one cycle. During that cycle r_shreg still holds the
    // finished word, while a new bit may already be shifting in behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_COLLECT;
            r_shreg   <= '0;
            r_word    <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state <= S_COLLECT;
`ifdef PARITY_CHECK_EN
            r_perr  <= 1'b0;
`endif
            // Buffer: load the finished word when the buffer is free or
            // draining on this edge; otherwise drop the word and flag it.
            if (r_state == S_COMPLETE) begin
                if (!r_valid || bus.word_ready) begin
                    r_word  <= r_shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && bus.word_ready) begin
                r_valid <= 1'b0;
            end

            if (bus.frame_start) begin
                r_shreg <= '0;
                r_count <= '0;
            end

            if (bus.bit_valid) begin
`ifdef PARITY_CHECK_EN
                // The parity bit is checked, never shifted in.
                if (w_is_par) begin
                    r_count <= '0;
                    if (w_par_ok) r_state <= S_COMPLETE;
                    else          r_perr  <= 1'b1;
                end else begin
                    r_shreg <= w_shifted;
                    r_count <= w_cnt_base + CW'(1);
                end
`else
                r_shreg <= w_shifted;
                if (w_last) begin
                    r_count <= '0;
                    r_state <= S_COMPLETE;
                end else begin
                    r_count <= w_cnt_base + CW'(1);
                end
`endif
            end
        end
    end

    assign bus.word_out   = r_word;
    assign bus.word_valid = r_valid;
    assign bus.bit_count  = r_count;
    assign bus.overrun    = r_overrun;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = r_perr;
`endif

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler with WIDTH=3.
// Two instances, one MSB-first and one LSB-first, receive identical stimulus.
// A queue-based model of the received bits predicts every output.
// It is compared against both instances on each falling edge.
// Directed test-plan sequences with literal expectations are followed by a
// randomized run.
module tb_serial_word_assembler;
    localparam int W  = 3;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_word_assembler_if #(.WIDTH(W)) ifm ();
    serial_word_assembler_if #(.WIDTH(W)) ifl ();

    serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .bus(ifm));
    serial_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .bus(ifl));

    int errors = 0;
    int checks = 0;
    bit en = 0;

    // Reference model state.
    bit           q[$];
    bit           m_valid, m_ovr, m_perr, m_pend;
    bit [W-1:0]   m_wm, m_wl, p_m, p_l;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [W-1:0] pack(input bit msb);
        bit [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb) w[W-1-i] = q[i];
            else     w[i]     = q[i];
        end
        return w;
    endfunction

    // Advance the model by one clock edge, using the inputs held before the edge.
    task automatic model_step(input bit rst, input bit bv, input bit b, input bit fs, input bit rdy);
        bit par;
        if (rst) begin
            q.delete();
            m_valid = 0; m_ovr = 0; m_perr = 0; m_pend = 0;
            m_wm = '0; m_wl = '0;
            return;
        end
        if (m_pend) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_wm = p_m; m_wl = p_l;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_pend = 0;
        m_perr = 0;
        if (fs) q.delete();
        if (bv) begin
`ifdef PARITY_CHECK_EN
            if (q.size() == W) begin
                par = b;
                foreach (q[i]) par ^= q[i];
                if (!par) begin
                    m_pend = 1; p_m = pack(1); p_l = pack(0);
                end else begin
                    m_perr = 1;
                end
                q.delete();
            end else begin
                q.push_back(b);
            end
`else
            par = 0;
            q.push_back(b);
            if (q.size() == W) begin
                m_pend = 1; p_m = pack(1); p_l = pack(0);
                q.delete();
            end
`endif
        end
    endtask

    // Drive one cycle. The model steps right after the edge. The task returns
    // on the next falling edge, once the compare process has run there.
    task automatic cyc(input bit rst, input bit bv, input bit b, input bit fs, input bit rdy);
        reset = rst;
        ifm.bit_valid = bv; ifm.bit_in = b; ifm.frame_start = fs; ifm.word_ready = rdy;
        ifl.bit_valid = bv; ifl.bit_in = b; ifl.frame_start = fs; ifl.word_ready = rdy;
        @(posedge clk);
        model_step(rst, bv, b, fs, rdy);
        @(negedge clk);
    endtask

    task automatic bit1(input bit b, input bit rdy);
        cyc(0, 1, b, 0, rdy);
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (en) begin
            cmp("m_valid", ifm.word_valid, m_valid);
            cmp("m_word",  ifm.word_out,   m_wm);
            cmp("m_count", ifm.bit_count,  q.size());
            cmp("m_ovr",   ifm.overrun,    m_ovr);
            cmp("l_valid", ifl.word_valid, m_valid);
            cmp("l_word",  ifl.word_out,   m_wl);
            cmp("l_count", ifl.bit_count,  q.size());
            cmp("l_ovr",   ifl.overrun,    m_ovr);
`ifdef PARITY_CHECK_EN
            cmp("m_perr",  ifm.parity_err, m_perr);
            cmp("l_perr",  ifl.parity_err, m_perr);
`endif
        end
    end

    initial begin
        reset = 1;
        ifm.bit_valid = 0; ifm.bit_in = 0; ifm.frame_start = 0; ifm.word_ready = 0;
        ifl.bit_valid = 0; ifl.bit_in = 0; ifl.frame_start = 0; ifl.word_ready = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        en = 1;
        cyc(1, 1, 1, 1, 1);
        cmp("rst_valid", ifm.word_valid, 0);
        cmp("rst_count", ifm.bit_count, 0);
        cmp("rst_word",  ifm.word_out, 0);

`ifndef PARITY_CHECK_EN
        // Three ones, consumer ready: a single-cycle word 111.
        cyc(0, 0, 0, 0, 1);
        bit1(1, 1); bit1(1, 1); bit1(1, 1);
        cyc(0, 0, 0, 0, 1);
        cmp("t1_valid", ifm.word_valid, 1);
        cmp("t1_word",  ifm.word_out, 3'b111);
        cmp("t1_model", m_wm, 3'b111);
        cyc(0, 0, 0, 0, 1);
        cmp("t1_drop",  ifm.word_valid, 0);
        cmp("t1_ovr",   ifm.overrun, 0);

        // Bits 1,0,0 in both bit orders.
        bit1(1, 1); bit1(0, 1); bit1(0, 1);
        cyc(0, 0, 0, 0, 1);
        cmp("t2_msb", ifm.word_out, 3'b100);
        cmp("t2_lsb", ifl.word_out, 3'b001);
        cmp("t2_model", m_wl, 3'b001);

        // A partial word is abandoned by frame_start.
        cyc(0, 0, 0, 0, 1);
        bit1(1, 1);               cmp("t3_c1", ifm.bit_count, 1);
        bit1(0, 1);               cmp("t3_c2", ifm.bit_count, 2);
        cyc(0, 1, 0, 1, 1);       cmp("t3_c3", ifm.bit_count, 1);
        bit1(1, 1);               cmp("t3_c4", ifm.bit_count, 2);
        bit1(1, 1);               cmp("t3_c5", ifm.bit_count, 0);
        cyc(0, 0, 0, 0, 1);
        cmp("t3_word", ifm.word_out, 3'b011);
        cmp("t3_lsb",  ifl.word_out, 3'b110);

        // Overrun: the second word is dropped; the first is kept and then drained.
        cyc(0, 0, 0, 0, 1);
        bit1(1, 0); bit1(0, 0); bit1(1, 0);
        bit1(0, 0); bit1(1, 0); bit1(0, 0);
        cyc(0, 0, 0, 0, 0);
        cmp("t4_word",  ifm.word_out, 3'b101);
        cmp("t4_valid", ifm.word_valid, 1);
        cmp("t4_ovr",   ifm.overrun, 1);
        cyc(0, 0, 0, 0, 1);
        cmp("t4_xfer",  ifm.word_valid, 0);
        cmp("t4_hold",  ifm.word_out, 3'b101);
        cmp("t4_stky",  ifm.overrun, 1);

        // Back-to-back words with no bubble, then a reset in the middle of a word.
        cyc(1, 0, 0, 0, 0);
        bit1(1, 1); bit1(1, 1); bit1(0, 1); bit1(0, 1);
        cmp("t5_w1", ifm.word_out, 3'b110);
        cmp("t5_v1", ifm.word_valid, 1);
        bit1(1, 1); bit1(1, 1);
        cyc(0, 0, 0, 0, 1);
        cmp("t5_w2", ifm.word_out, 3'b011);
        cmp("t5_v2", ifm.word_valid, 1);
        bit1(1, 1);
        cyc(1, 1, 1, 0, 1);
        cmp("t5_rw", ifm.word_out, 0);
        cmp("t5_rv", ifm.word_valid, 0);
        cmp("t5_rc", ifm.bit_count, 0);
`else
        // Good parity is accepted; bad parity produces a single error pulse.
        cyc(0, 0, 0, 0, 1);
        bit1(1, 1); bit1(1, 1); bit1(1, 1); bit1(1, 1);
        cyc(0, 0, 0, 0, 1);
        cmp("p1_valid", ifm.word_valid, 1);
        cmp("p1_word",  ifm.word_out, 3'b111);
        cyc(0, 0, 0, 0, 1);
        bit1(1, 1); bit1(1, 1); bit1(1, 1); bit1(0, 1);
        cmp("p2_perr",  ifm.parity_err, 1);
        cmp("p2_model", m_perr, 1);
        cyc(0, 0, 0, 0, 1);
        cmp("p2_pulse", ifm.parity_err, 0);
        cmp("p2_valid", ifm.word_valid, 0);
`endif

        // Randomized traffic.
        cyc(1, 0, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 9) < 7),
                1'($urandom),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) < 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
Upstream feeder for the 3-input combinational function stages in the Binary Representations set. It collects a serial bit stream, one bit per qualified cycle, into a WIDTH-bit parallel word (bit order {A,B,C,...}). It presents each completed word through a one-entry output buffer with a valid/ready handshake. Shifting continues while a previous word waits in the buffer; the overrun condition is flagged, never silently merged.

Parameters:
WIDTH, 3, bits per assembled word (2..16)
MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1] (A); 0 = first bit lands in word_out[0]

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is sampled on this cycle
frame_start  input  1  discard any partial word; when bit_valid=1 in the same cycle, bit_in is bit 0 of a new word
word_out  output  WIDTH  assembled word, stable while word_valid=1
word_valid  output  1  output buffer holds an unconsumed word
word_ready  input  1  consumer accepts word_out when word_valid=1 on this cycle
bit_count  output  clog2(WIDTH+1)  bits collected into the current partial word
overrun  output  1  sticky: a completed word was dropped because the buffer was full

Behaviour:
- Reset (synchronous): word_out=0, word_valid=0, bit_count=0, overrun=0, shift register=0, FSM to COLLECT. Reset wins over every other input in the same cycle, including mid-word and with a word pending.
- FSM states:
  - COLLECT: partial word in progress.
  - COMPLETE: internal, one cycle. Entered when bit WIDTH is taken; transfers the word to the buffer, then returns to COLLECT.
- The COMPLETE transfer is not a stall: bit_valid on that cycle is accepted as bit 0 of the next word. Back-to-back words at 1 bit/cycle are supported.
- Shift rules:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], bit_in}.
  - MSB_FIRST=0: shreg <= {bit_in, shreg[WIDTH-1:1]}.
  - bit_count increments on each accepted bit. It wraps to 0 on the bit that completes the word.
- frame_start=1: bit_count forced to 0 and shreg cleared before the shift. With bit_valid=1 in the same cycle, bit_count becomes 1. The buffer and overrun are unaffected.
- Latency: word_valid rises on the cycle after the clock edge that accepts bit WIDTH (2 edges from final bit sample to visible output).
- Handshake:
  - Transfer occurs on any edge where word_valid=1 and word_ready=1.
  - After transfer, word_valid=0 unless a new word loads on the same edge.
  - word_out holds its last value after a transfer; it is not cleared.
- Buffer full, new word completes, word_ready=1 on that edge: old word consumed and new word loaded on the same edge; word_valid stays 1; no overrun.
- Buffer full, new word completes, word_ready=0: new word discarded; buffer keeps the old word; overrun set and held until reset.
- bit_valid=0 cycles: no state change (apart from frame_start and the handshake). Gaps of any length are allowed mid-word.
- word_ready while word_valid=0: ignored.

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - bit_count runs 0..WIDTH.
  - On the parity bit, if XOR(data, parity)=0, the word loads under the normal buffer/overrun rules.
  - Otherwise the word is discarded and an added output parity_err (1 bit, reset 0) pulses high for exactly one cycle. The buffer and overrun are untouched.
- Undefined: no parity bit, no parity_err port; frames are exactly WIDTH bits.

Test Plan:
- Reset, WIDTH=3, MSB_FIRST=1; bits 1,1,1 on consecutive cycles with word_ready=1 -> word_out=3'b111, word_valid high for exactly 1 cycle, overrun=0.
- MSB_FIRST=0; bits 1,0,0 -> word_out=3'b001. MSB_FIRST=1, same bits -> 3'b100.
- Bits 1,0 then frame_start with bit 0, then 1,1 -> word_out=3'b011; the partial "10" is dropped; bit_count sequence 1,2,1,2,0.
- word_ready=0; send 3'b101 then 3'b010 -> word_out stays 3'b101, overrun=1. Raise word_ready -> one transfer of 3'b101; overrun stays 1.
- Continuous 6-bit stream 1,1,0,0,1,1 with word_ready=1 -> words 3'b110 then 3'b011, no bubble between them. Assert reset mid-second-word -> all outputs 0 on the next cycle.
- PARITY_CHECK_EN, WIDTH=3: 1,1,1,1 -> word 3'b111 accepted. 1,1,1,0 -> parity_err pulse of 1 cycle and no word_valid.
